hfrv_trace_buffer: RTL and testbench

//  On-chip retire-trace capture buffer for the HF-RISC core. It is the synthesisable successor of the

---
 rtl/hfrv_trace_buffer.sv | 192 +++++++++++++++++++
 tb/tb_hfrv_trace_buffer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer: retire-trace capture RAM with trigger, post window and drain.
// Optional HFRV_TRACE_TIMESTAMP_EN adds a per-entry cycle stamp and the rd_ts port.
module hfrv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64
`ifdef HFRV_TRACE_TIMESTAMP_EN
    ,
    parameter int TS_W  = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_valid,
    input  logic [XLEN-1:0]          cap_pc,
    input  logic [XLEN-1:0]          cap_instr,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [XLEN-1:0]          trig_value,
    input  logic [XLEN-1:0]          trig_mask,
    input  logic                     trig_ext,
    input  logic [$clog2(DEPTH)-1:0] post_count,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [XLEN-1:0]          rd_instr,
`ifdef HFRV_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]          rd_ts,
`endif
    output logic [1:0]               state_o,
    output logic [15:0]              dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_remain;
    logic [1:0]        r_mode;
    logic [XLEN-1:0]   r_value;
    logic [XLEN-1:0]   r_mask;
    logic [AW-1:0]     r_post;
    logic              r_rd_valid;
    logic [XLEN-1:0]   r_rd_pc;
    logic [XLEN-1:0]   r_rd_instr;
    logic [15:0]       r_dropped;
    logic [XLEN-1:0]   r_ram_pc    [DEPTH];
    logic [XLEN-1:0]   r_ram_instr [DEPTH];

    logic              w_arm_ok;
    logic              w_store;
    logic              w_hit;
    logic              w_pc_match;
    logic              w_instr_match;
    logic              w_load;
    logic              w_pop;
    logic [AW-1:0]     w_rd;

    assign w_arm_ok      = arm && (r_state == S_IDLE);
    assign w_store       = cap_valid && (r_state == S_ARMED || r_state == S_POST);
    assign w_pc_match    = ((cap_pc ^ r_value) & r_mask) == '0;
    assign w_instr_match = ((cap_instr ^ r_value) & r_mask) == '0;
    // While draining, wr is frozen and count shrinks, so wr-count walks oldest-first.
    assign w_rd          = r_wr - r_count[AW-1:0];
    assign w_load        = (r_state == S_DRAIN) && (r_count != '0)
                           && (!r_rd_valid || rd_ready);
    assign w_pop         = r_rd_valid && rd_ready;

    // Trigger hit for the latched mode; external mode ignores the retire strobe
    always_comb begin
        w_hit = 1'b0;
        unique case (r_mode)
            2'd0:    w_hit = cap_valid;
            2'd1:    w_hit = cap_valid && w_pc_match;
            2'd2:    w_hit = cap_valid && w_instr_match;
            default: w_hit = trig_ext;
        endcase
    end

    // Next-state logic for the capture/drain sequence
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (arm) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (w_hit) w_state_nxt = (r_post == '0) ? S_DRAIN : S_POST;
            end
            S_POST: begin
                if (cap_valid && r_remain == AW'(1)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_count == '0 && (!r_rd_valid || rd_ready)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointers, trigger setup, drop counter and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wr       <= '0;
            r_count    <= '0;
            r_remain   <= '0;
            r_mode     <= '0;
            r_value    <= '0;
            r_mask     <= '0;
            r_post     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_dropped  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_ok) begin
                r_mode    <= trig_mode;
                r_value   <= trig_value;
                r_mask    <= trig_mask;
                r_post    <= post_count;
                r_count   <= '0;
                r_dropped <= '0;
            end
            if (w_store) begin
                r_wr <= r_wr + 1'b1;
                if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
            end
            if (r_state == S_ARMED && w_hit) begin
                r_remain <= r_post;
            end else if (r_state == S_POST && cap_valid) begin
                r_remain <= r_remain - 1'b1;
            end
            if (r_state == S_DRAIN && cap_valid && r_dropped != 16'hFFFF) begin
                r_dropped <= r_dropped + 1'b1;
            end
            if (w_load) begin
                r_count    <= r_count - 1'b1;
                r_rd_valid <= 1'b1;
                r_rd_pc    <= r_ram_pc[w_rd];
                r_rd_instr <= r_ram_instr[w_rd];
            end else if (w_pop) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Trace RAM write port
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_ram_pc[r_wr]    <= cap_pc;
            r_ram_instr[r_wr] <= cap_instr;
        end
    end

`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_rd_ts;
    logic [TS_W-1:0] r_ram_ts [DEPTH];

    // Free-running stamp, restarted by each accepted arm
    always_ff @(posedge clk) begin
        if (reset || w_arm_ok) r_ts <= '0;
        else                   r_ts <= r_ts + 1'b1;
    end

    // Stamp storage and read, aligned with the pc/instr read
    always_ff @(posedge clk) begin
        if (w_store) r_ram_ts[r_wr] <= r_ts;
        if (reset)       r_rd_ts <= '0;
        else if (w_load) r_rd_ts <= r_ram_ts[w_rd];
    end

    assign rd_ts = r_rd_ts;
`endif

    assign rd_valid = r_rd_valid;
    assign rd_pc    = r_rd_pc;
    assign rd_instr = r_rd_instr;
    assign state_o  = r_state;
    assign dropped  = r_dropped;

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// tb_hfrv_trace_buffer: table-driven capture runs with a drain scoreboard,
// plus hand sequences for arm/capture overlap, reset in POST and stamps.
`timescale 1ns/1ps
module tb_hfrv_trace_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            cap_valid;
    logic [31:0]     cap_pc;
    logic [31:0]     cap_instr;
    logic            arm;
    logic [1:0]      trig_mode;
    logic [31:0]     trig_value;
    logic [31:0]     trig_mask;
    logic            trig_ext;
    logic [AW-1:0]   post_count;
    logic            rd_ready;
    logic            rd_valid;
    logic [31:0]     rd_pc;
    logic [31:0]     rd_instr;
    logic [1:0]      state_o;
    logic [15:0]     dropped;
`ifdef HFRV_TRACE_TIMESTAMP_EN
    logic [15:0]     rd_ts;
    logic [15:0]     ts_q[$];
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] value;
        logic [31:0] mask;
        int          post;
        int          n_ret;
        logic [31:0] pc0;
        int          opimm_at;
        int          ext_at;
        bit          toggle;
        int          hit;
        int          exp_n;
        int          exp_drop;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[5];

    hfrv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cap_valid  (cap_valid),
        .cap_pc     (cap_pc),
        .cap_instr  (cap_instr),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .trig_ext   (trig_ext),
        .post_count (post_count),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_pc      (rd_pc),
        .rd_instr   (rd_instr),
`ifdef HFRV_TRACE_TIMESTAMP_EN
        .rd_ts      (rd_ts),
`endif
        .state_o    (state_o),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input int i, input int opimm_at);
        logic [31:0] w;
        w = 32'(i) << 7;
        return (i == opimm_at) ? (w | 32'h13) : (w | 32'h33);
    endfunction

    task automatic drain(input bit toggle, output int n,
                         output logic [31:0] first, output logic [31:0] last);
        bit          done;
        bit          hold;
        logic [31:0] hpc;
        logic [31:0] hin;
        ent_t        e;
        n = 0;
        first = '0;
        last = '0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            rd_ready = toggle ? c[0] : 1'b1;
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'(n), 64'(n + 1));
                end else begin
                    e = sb.pop_front();
                    check("rd_pc", rd_pc, e.pc);
                    check("rd_instr", rd_instr, e.instr);
                end
`ifdef HFRV_TRACE_TIMESTAMP_EN
                ts_q.push_back(rd_ts);
`endif
                if (n == 0) first = rd_pc;
                last = rd_pc;
                n++;
            end
            hold = rd_valid && !rd_ready;
            hpc  = rd_pc;
            hin  = rd_instr;
            tick;
            if (hold) begin
                check("stall_valid", rd_valid, 1);
                check("stall_pc", rd_pc, hpc);
                check("stall_instr", rd_instr, hin);
            end
            if (state_o == 2'd0) done = 1'b1;
        end
        rd_ready = 1'b0;
        check("drain_done", done, 1);
        check("drain_rd_valid_low", rd_valid, 0);
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [31:0] val,
                          input logic [31:0] mask, input int post);
        trig_mode  = mode;
        trig_value = val;
        trig_mask  = mask;
        post_count = AW'(post);
        arm = 1'b1;
        tick;
        arm = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          n;
        logic [31:0] first;
        logic [31:0] last;
        logic [31:0] pc;
        logic [31:0] ins;
        sb.delete();
        rd_ready = 1'b0;
        do_arm(v.mode, v.value, v.mask, v.post);
        check($sformatf("v%0d_armed", id), state_o, 1);
        for (int i = 0; i < v.n_ret; i++) begin
            pc  = v.pc0 + 32'(4 * i);
            ins = instr_of(i, v.opimm_at);
            cap_valid = 1'b1;
            cap_pc    = pc;
            cap_instr = ins;
            trig_ext  = (i == v.ext_at);
            if (i <= v.hit + v.post) begin
                sb.push_back(ent_t'({pc, ins}));
                if (sb.size() > DEPTH) void'(sb.pop_front());
            end
            tick;
        end
        cap_valid = 1'b0;
        trig_ext  = 1'b0;
        tick;
        check($sformatf("v%0d_drain_state", id), state_o, 3);
        check($sformatf("v%0d_dropped", id), dropped, 64'(v.exp_drop));
        drain(v.toggle, n, first, last);
        check($sformatf("v%0d_count", id), 64'(n), 64'(v.exp_n));
        check($sformatf("v%0d_first", id), first, v.exp_first);
        check($sformatf("v%0d_last", id), last, v.exp_last);
        check($sformatf("v%0d_sb_empty", id), 64'(sb.size()), 0);
    endtask

    initial begin
        int          n;
        logic [31:0] first;
        logic [31:0] last;

        vecs[0] = '{2'd0, 32'h0, 32'h0, 3, 5, 32'h100, -1, -1, 1'b0,
                    0, 4, 1, 32'h100, 32'h10C};
        vecs[1] = '{2'd1, 32'h200, 32'hFFFFFFFF, 2, 140, 32'h0, -1, -1, 1'b0,
                    128, 64, 9, 32'h10C, 32'h208};
        vecs[2] = '{2'd2, 32'h13, 32'h7F, 0, 10, 32'h400, 6, -1, 1'b0,
                    6, 7, 3, 32'h400, 32'h418};
        vecs[3] = '{2'd3, 32'h0, 32'h0, 1, 6, 32'h800, -1, 2, 1'b1,
                    2, 4, 2, 32'h800, 32'h80C};
        vecs[4] = '{2'd1, 32'h40, 32'hF0, 5, 30, 32'h1000, -1, -1, 1'b1,
                    16, 22, 8, 32'h1000, 32'h1054};

        reset = 1'b1;
        cap_valid = 1'b0;
        cap_pc = '0;
        cap_instr = '0;
        arm = 1'b0;
        trig_mode = '0;
        trig_value = '0;
        trig_mask = '0;
        trig_ext = 1'b0;
        post_count = '0;
        rd_ready = 1'b0;
        tick;
        tick;
        check("rst_state", state_o, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_pc", rd_pc, 0);
        check("rst_rd_instr", rd_instr, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;
        tick;

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // arm together with a retire: that beat must not be captured
        sb.delete();
        cap_valid = 1'b1;
        cap_pc = 32'hDEAD0000;
        cap_instr = 32'h0;
        do_arm(2'd0, 32'h0, 32'h0, 0);
        cap_pc = 32'h500;
        cap_instr = 32'h00100093;
        sb.push_back(ent_t'({32'h500, 32'h00100093}));
        tick;
        cap_valid = 1'b0;
        tick;
        check("ovl_state", state_o, 3);
        drain(1'b0, n, first, last);
        check("ovl_count", 64'(n), 1);
        check("ovl_pc", first, 32'h500);

        // reset during POST, stray arm ignored, then a normal re-arm
        do_arm(2'd0, 32'h0, 32'h0, 10);
        for (int i = 0; i < 3; i++) begin
            cap_valid = 1'b1;
            cap_pc = 32'h900 + 32'(4 * i);
            tick;
        end
        cap_valid = 1'b0;
        check("post_state", state_o, 2);
        arm = 1'b1;
        trig_mode = 2'd3;
        tick;
        arm = 1'b0;
        check("post_arm_ignored", state_o, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_post_state", state_o, 0);
        check("rst_post_rd_valid", rd_valid, 0);
        check("rst_post_dropped", dropped, 0);
        tick;
        run_vec(vecs[0], 5);

`ifdef HFRV_TRACE_TIMESTAMP_EN
        // retires every third cycle after arm: consecutive stamps differ by 3
        sb.delete();
        ts_q.delete();
        do_arm(2'd0, 32'h0, 32'h0, 3);
        for (int i = 0; i < 4; i++) begin
            tick;
            tick;
            cap_valid = 1'b1;
            cap_pc = 32'hA00 + 32'(4 * i);
            cap_instr = 32'h13;
            sb.push_back(ent_t'({cap_pc, cap_instr}));
            tick;
            cap_valid = 1'b0;
        end
        tick;
        drain(1'b0, n, first, last);
        check("ts_count", 64'(n), 4);
        for (int i = 1; i < ts_q.size(); i++) begin
            check($sformatf("ts_delta%0d", i), 64'(ts_q[i] - ts_q[i-1]), 3);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
